pll_reconfig_sequencer: RTL
===========================

// Module: pll_reconfig_sequencer
// PURPOSE
//  Owns the PLL reconfiguration management port. Filters a game-speed request (native / 60Hz underclock),
//  then writes mode -> fractional-M -> start to the reconfig block with waitrequest handshaking.
//  Waits for PLL relock and reports done or error. Sits beside pll/pll_cfg on the 50 MHz management clock.
// PARAMETERS
//  FRAC_NATIVE      32'd3639383488  counter-7 word for native clock
//  FRAC_UNDERCLOCK  32'd3262113561  counter-7 word for ~1% underclock
//  FILTER_LEN       4               consecutive equal synced samples needed to accept a request (>=1)
//  ACK_TIMEOUT      4096            max cycles a write may stall on waitrequest
//  SETTLE_CYCLES    64              cycles after start write before pll_locked is sampled
//  LOCK_TIMEOUT     1000000         max cycles to wait for pll_locked after settle
// PORTS
//  clk_50m           in   1   management clock
//  reset             in   1   asynchronous, active-low reset
//  underclock_req    in   1   requested speed, async (OSD status); 1 = underclock
//  pll_locked        in   1   PLL lock, async; 2-FF synchronised internally
//  mgmt_waitrequest  in   1   reconfig stall; write accepted on cycle mgmt_write=1 && waitrequest=0
//  mgmt_write        out  1   write strobe
//  mgmt_address      out  6   register address
//  mgmt_writedata    out  32  register data
//  busy              out  1   high from first write issue until DONE/ERROR exit
//  cfg_done          out  1   one-cycle pulse on successful relock
//  cfg_error         out  1   sticky: ack or lock timeout
//  underclock_active out  1   speed last successfully applied (feeds sound pitch compensation)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; applied value INVALID; timers 0. Reset mid-sequence aborts at once,
//   no partial write completes; INVALID forces reprogramming once reset releases.
//  Input path: underclock_req and pll_locked each 2-FF synced. Filter counter reloads on any synced
//   change; request is "stable" after FILTER_LEN equal samples.
//  IDLE -> MODE when stable && (applied INVALID || stable value != applied) && !cfg_error_block.
//   Target latched on this transition; later request changes ignored until sequence ends.
//  MODE:  addr 0, data 0 (waitrequest mode).  FRAC: addr 7, data target?FRAC_UNDERCLOCK:FRAC_NATIVE.
//   START: addr 2, data 0. Each write state holds mgmt_write=1 with address/data constant until
//   accepted; next cycle mgmt_write=0 for exactly one cycle before next write (no back-to-back).
//  Ack timer counts stalled cycles per write; reaching ACK_TIMEOUT -> ERROR, mgmt_write dropped same cycle.
//  SETTLE: count SETTLE_CYCLES ignoring pll_locked. LOCK: wait synced pll_locked=1; LOCK_TIMEOUT -> ERROR.
//  DONE (1 cycle): cfg_done=1, applied<=target, underclock_active<=target, cfg_error<=0 -> IDLE.
//  ERROR (1 cycle): cfg_error<=1, applied<=INVALID, underclock_active unchanged -> IDLE.
//   cfg_error_block set; cleared only when stable request differs from the failed target (no retry loop).
//  busy=1 in MODE..LOCK inclusive; 0 in IDLE/DONE/ERROR.
//  Minimum latency stable->cfg_done with no stalls: 3 writes x2 + SETTLE_CYCLES + 1 lock cycle + 1.
//  Request toggling faster than FILTER_LEN never starts a sequence. Request returning to applied
//   value during a sequence causes a second sequence afterwards (target != new stable).
//  Timers saturate; widths sized by $clog2 of each parameter +1.
// TESTING
//  Reset release, req=0, waitrequest=0, locked=1 -> writes (0,0),(7,3639383488),(2,0) in order; cfg_done once; active=0.
//  req 0->1 after done, waitrequest high 10 cycles per write -> each write held 10 cycles stable; active=1 after lock.
//  req pulses 1 for 2 cycles (FILTER_LEN=4) -> no mgmt_write, busy stays 0.
//  waitrequest stuck high -> after ACK_TIMEOUT cycles mgmt_write=0, cfg_error=1, no re-attempt until req changes.
//  locked held 0 after start -> cfg_error at SETTLE+LOCK_TIMEOUT; then req toggle -> clean sequence, error clears.
//  Assert reset during FRAC stall -> mgmt_write=0 immediately; after release full sequence reissued from MODE.

Source files
------------

// File: rtl/pll_reconfig_sequencer.sv
// PLL reconfiguration sequencer: filters the speed request, then writes mode, fractional-M and start
// to the reconfig management port with waitrequest handshaking, and waits for relock.
`timescale 1ns/1ps
module pll_reconfig_sequencer #(
  parameter logic [31:0] FRAC_NATIVE     = 32'd3639383488,
  parameter logic [31:0] FRAC_UNDERCLOCK = 32'd3262113561,
  parameter int unsigned FILTER_LEN      = 4,
  parameter int unsigned ACK_TIMEOUT     = 4096,
  parameter int unsigned SETTLE_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT    = 1000000
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock_req,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic        underclock_active
);

  localparam int FILT_W   = $clog2(FILTER_LEN) + 1;
  localparam int ACK_W    = $clog2(ACK_TIMEOUT) + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int LOCK_W   = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [FILT_W-1:0]   FILT_FULL   = FILT_W'(FILTER_LEN);
  localparam logic [ACK_W-1:0]    ACK_LAST    = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_GAP_MF, S_FRAC, S_GAP_FS, S_START, S_SETTLE, S_LOCK, S_DONE, S_ERROR
  } state_t;

  state_t state, state_n;

  logic                req_sync_p0, req_sync_p1, req_prev_p2;
  logic                lock_sync_p0, lock_sync_p1;
  logic [FILT_W-1:0]   filt_cnt;
  logic [ACK_W-1:0]    ack_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                target, applied_valid, applied_val, err_block;
  logic                stable, stable_val, start_ok, in_write;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: previous synced request for change detection
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      req_sync_p0  <= 1'b0;
      req_sync_p1  <= 1'b0;
      req_prev_p2  <= 1'b0;
      lock_sync_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
      filt_cnt     <= '0;
    end else begin
      req_sync_p0  <= underclock_req;
      req_sync_p1  <= req_sync_p0;
      req_prev_p2  <= req_sync_p1;
      lock_sync_p0 <= pll_locked;
      lock_sync_p1 <= lock_sync_p0;
      if (req_sync_p1 != req_prev_p2) filt_cnt <= FILT_W'(1);
      else filt_cnt <= FILT_W'(sat_inc(32'(filt_cnt), FILTER_LEN));
    end
  end

  assign stable     = (filt_cnt >= FILT_FULL);
  assign stable_val = req_prev_p2;
  // A failed target is not retried until the request moves away from it
  assign start_ok   = stable && (!applied_valid || (stable_val != applied_val))
                      && (!err_block || (stable_val != target));
  assign in_write   = (state == S_MODE) || (state == S_FRAC) || (state == S_START);

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    busy           = 1'b0;
    cfg_done       = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_n = S_MODE;
      S_MODE: begin
        busy       = 1'b1;
        mgmt_write = 1'b1;
        if (!mgmt_waitrequest)       state_n = S_GAP_MF;
        else if (ack_cnt == ACK_LAST) state_n = S_ERROR;
      end
      S_GAP_MF: begin
        busy    = 1'b1;
        state_n = S_FRAC;
      end
      S_FRAC: begin
        busy           = 1'b1;
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = target ? FRAC_UNDERCLOCK : FRAC_NATIVE;
        if (!mgmt_waitrequest)       state_n = S_GAP_FS;
        else if (ack_cnt == ACK_LAST) state_n = S_ERROR;
      end
      S_GAP_FS: begin
        busy    = 1'b1;
        state_n = S_START;
      end
      S_START: begin
        busy         = 1'b1;
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
        if (!mgmt_waitrequest)       state_n = S_SETTLE;
        else if (ack_cnt == ACK_LAST) state_n = S_ERROR;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_n = S_LOCK;
      end
      S_LOCK: begin
        busy = 1'b1;
        if (lock_sync_p1)                state_n = S_DONE;
        else if (lock_cnt == LOCK_LAST) state_n = S_ERROR;
      end
      S_DONE: begin
        cfg_done = 1'b1;
        state_n  = S_IDLE;
      end
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Per-phase timers restart from zero whenever their phase is not active
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      ack_cnt    <= '0;
      settle_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      if (in_write && mgmt_waitrequest) ack_cnt <= ACK_W'(sat_inc(32'(ack_cnt), ACK_TIMEOUT));
      else                              ack_cnt <= '0;
      if (state == S_SETTLE) settle_cnt <= SETTLE_W'(sat_inc(32'(settle_cnt), SETTLE_CYCLES));
      else                   settle_cnt <= '0;
      if (state == S_LOCK) lock_cnt <= LOCK_W'(sat_inc(32'(lock_cnt), LOCK_TIMEOUT));
      else                 lock_cnt <= '0;
    end
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      target            <= 1'b0;
      applied_valid     <= 1'b0;
      applied_val       <= 1'b0;
      underclock_active <= 1'b0;
      cfg_error         <= 1'b0;
      err_block         <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_ok) target <= stable_val;
      if (err_block && stable && (stable_val != target)) err_block <= 1'b0;
      case (state)
        S_DONE: begin
          applied_valid     <= 1'b1;
          applied_val       <= target;
          underclock_active <= target;
          cfg_error         <= 1'b0;
        end
        S_ERROR: begin
          applied_valid <= 1'b0;
          cfg_error     <= 1'b1;
          err_block     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
